dmem_arbiter: RTL and testbench

Shares the single-port 16-bit data memory between the pipelined CPU's data port and the Raspberry Pi host port used for program loading and debug readback. The block picks one requester per cycle and drives the memory address, write data and write enable. It routes the one-cycle-late read data back to whichever requester issued the read. The CPU has priority, but a starvation counter guarantees the host a slot, and a host lock freezes the CPU during bulk loads.

---
 rtl/dmem_arbiter.sv | 128 ++++++++++++
 tb/tb_dmem_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the CPU data port and the host port.
// The CPU has priority, a wait counter forces a host slot, and host_lock gives the host exclusive access.
module dmem_arbiter #(
  parameter int AW       = 13,
  parameter int DW       = 16,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_adr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_stall,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_rvalid,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_adr,
  input  logic [DW-1:0] host_wdata,
  input  logic          host_lock,
  output logic          host_gnt,
  output logic [DW-1:0] host_rdata,
  output logic          host_rvalid,
  output logic          mem_we,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {CPU_PRI, HOST_FORCE, LOCKED} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_HOST} owner_t;

  localparam logic [3:0] WAIT_MAX  = 4'(MAX_WAIT);
  localparam logic [3:0] WAIT_TRIP = 4'(MAX_WAIT - 1);

  state_t        state_reg;
  logic [3:0]    wait_cnt_reg;
  owner_t        rd_owner_reg;
  logic [DW-1:0] cpu_rdata_reg;
  logic [DW-1:0] host_rdata_reg;
  logic          cpu_granted;
  logic          host_granted;

  // Grant selection depends only on registered state and requests, never on mem_rdata.
  always_comb begin
    cpu_granted  = 1'b0;
    host_granted = 1'b0;
    case (state_reg)
      CPU_PRI: begin
        if (cpu_req)       cpu_granted  = 1'b1;
        else if (host_req) host_granted = 1'b1;
      end
      HOST_FORCE: begin
        if (host_req)      host_granted = 1'b1;
        else if (cpu_req)  cpu_granted  = 1'b1;
      end
      LOCKED: begin
        host_granted = host_req;
      end
      default: begin
        cpu_granted  = 1'b0;
        host_granted = 1'b0;
      end
    endcase
  end

  assign cpu_stall = cpu_req & ~cpu_granted;
  assign host_gnt  = host_req & host_granted;

  always_comb begin
    mem_we    = 1'b0;
    mem_adr   = '0;
    mem_wdata = '0;
    if (cpu_granted) begin
      mem_we    = cpu_we;
      mem_adr   = cpu_adr;
      mem_wdata = cpu_wdata;
    end else if (host_granted) begin
      mem_we    = host_we;
      mem_adr   = host_adr;
      mem_wdata = host_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= CPU_PRI;
      wait_cnt_reg   <= '0;
      rd_owner_reg   <= OWN_NONE;
      cpu_rdata_reg  <= '0;
      host_rdata_reg <= '0;
    end else begin
      if (host_req && !host_gnt) begin
        if (wait_cnt_reg != WAIT_MAX) wait_cnt_reg <= wait_cnt_reg + 4'd1;
      end else begin
        wait_cnt_reg <= '0;
      end

      if (host_lock) begin
        state_reg <= LOCKED;
      end else begin
        case (state_reg)
          CPU_PRI:
            if (host_req && !host_gnt && wait_cnt_reg >= WAIT_TRIP) state_reg <= HOST_FORCE;
          HOST_FORCE:
            if (host_gnt || !host_req) state_reg <= CPU_PRI;
          default:
            state_reg <= CPU_PRI;
        endcase
      end

      if (cpu_granted && !cpu_we)       rd_owner_reg <= OWN_CPU;
      else if (host_gnt && !host_we)    rd_owner_reg <= OWN_HOST;
      else                              rd_owner_reg <= OWN_NONE;

      // Keep the returned word so a non-owner's rdata stays stable afterwards.
      if (rd_owner_reg == OWN_CPU)  cpu_rdata_reg  <= mem_rdata;
      if (rd_owner_reg == OWN_HOST) host_rdata_reg <= mem_rdata;
    end
  end

  assign cpu_rvalid  = (rd_owner_reg == OWN_CPU);
  assign host_rvalid = (rd_owner_reg == OWN_HOST);
  assign cpu_rdata   = (rd_owner_reg == OWN_CPU)  ? mem_rdata : cpu_rdata_reg;
  assign host_rdata  = (rd_owner_reg == OWN_HOST) ? mem_rdata : host_rdata_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed bench for dmem_arbiter with a cycle-level model of who owns the memory.
module tb_dmem_arbiter;
  localparam int AW = 13;
  localparam int DW = 16;
  localparam int MAX_WAIT = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_adr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_stall, cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          host_req = 1'b0, host_we = 1'b0, host_lock = 1'b0;
  logic [AW-1:0] host_adr = '0;
  logic [DW-1:0] host_wdata = '0;
  logic          host_gnt, host_rvalid;
  logic [DW-1:0] host_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .host_req(host_req), .host_we(host_we), .host_adr(host_adr), .host_wdata(host_wdata),
    .host_lock(host_lock), .host_gnt(host_gnt), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory device attached to the DUT bus: registered read, one cycle latency.
  logic [DW-1:0] env_mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    mem_rdata <= env_mem[mem_adr];
    if (mem_we) env_mem[mem_adr] <= mem_wdata;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The host owns the memory in a cycle iff host_lock was high at the previous edge.
  // A forced host slot lasts exactly one cycle and follows MAX_WAIT-1 counted waits.
  logic [DW-1:0] model_mem [0:(1<<AW)-1];
  bit            m_locked = 0, m_force = 0;
  int            m_waits = 0;
  int            m_owner = 0;
  logic [DW-1:0] m_rdval = '0, m_cpu_hold = '0, m_host_hold = '0;
  bit            cpu_win, host_win, nforce, e_we;
  logic [AW-1:0] e_adr;
  logic [DW-1:0] e_wd;

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      env_mem[i]   <= 16'(i * 37) ^ 16'h5A5A;
      model_mem[i] =  16'(i * 37) ^ 16'h5A5A;
    end
  end

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (m_locked) begin
        cpu_win = 0; host_win = host_req;
      end else if (m_force) begin
        host_win = host_req; cpu_win = cpu_req && !host_req;
      end else begin
        cpu_win = cpu_req; host_win = host_req && !cpu_req;
      end
      e_we = 0; e_adr = '0; e_wd = '0;
      if (cpu_win) begin e_we = cpu_we; e_adr = cpu_adr; e_wd = cpu_wdata; end
      else if (host_win) begin e_we = host_we; e_adr = host_adr; e_wd = host_wdata; end

      chk("cpu_stall", 32'(cpu_stall), 32'(cpu_req && !cpu_win));
      chk("host_gnt", 32'(host_gnt), 32'(host_win));
      chk("mem_we", 32'(mem_we), 32'(e_we));
      chk("mem_adr", 32'(mem_adr), 32'(e_adr));
      chk("mem_wdata", 32'(mem_wdata), 32'(e_wd));
      chk("cpu_rvalid", 32'(cpu_rvalid), 32'(m_owner == 1));
      chk("host_rvalid", 32'(host_rvalid), 32'(m_owner == 2));
      chk("cpu_rdata", 32'(cpu_rdata), 32'((m_owner == 1) ? m_rdval : m_cpu_hold));
      chk("host_rdata", 32'(host_rdata), 32'((m_owner == 2) ? m_rdval : m_host_hold));

      if (e_we) model_mem[e_adr] = e_wd;
      if (reset) begin
        m_locked = 0; m_force = 0; m_waits = 0; m_owner = 0;
        m_rdval = '0; m_cpu_hold = '0; m_host_hold = '0;
      end else begin
        if (m_owner == 1) m_cpu_hold = m_rdval;
        if (m_owner == 2) m_host_hold = m_rdval;
        nforce = !host_lock && !m_locked && !m_force && host_req && !host_win &&
                 (m_waits >= MAX_WAIT - 1);
        if (host_req && !host_win) m_waits = (m_waits + 1 > MAX_WAIT) ? MAX_WAIT : m_waits + 1;
        else m_waits = 0;
        m_locked = host_lock;
        m_force = nforce;
        if (cpu_win && !cpu_we) begin m_owner = 1; m_rdval = model_mem[cpu_adr]; end
        else if (host_win && !host_we) begin m_owner = 2; m_rdval = model_mem[host_adr]; end
        else m_owner = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(bit cr, bit cw, int ca, int cd, bit hr, bit hw, int ha, int hd, bit lk);
    cpu_req = cr; cpu_we = cw; cpu_adr = 13'(ca); cpu_wdata = 16'(cd);
    host_req = hr; host_we = hw; host_adr = 13'(ha); host_wdata = 16'(hd);
    host_lock = lk;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic contention(string tag);
    for (int i = 0; i < 6; i++) begin
      tick();
      drive(1, 0, 200 + i, 0, i < 5, 0, 300, 0, 0);
      #2;
      if (i == 4) begin
        chk({tag, "_host_gnt"}, 32'(host_gnt), 32'd1);
        chk({tag, "_cpu_stall"}, 32'(cpu_stall), 32'd1);
        chk({tag, "_adr"}, 32'(mem_adr), 32'd300);
      end else begin
        chk({tag, "_host_gnt"}, 32'(host_gnt), 32'd0);
        chk({tag, "_cpu_stall"}, 32'(cpu_stall), 32'd0);
      end
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  bit hold, hr, hw, lk, cr, cw;
  int ha, hd, ca, cd;

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    repeat (3) tick();
    #2;
    chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    chk("rst_host_rvalid", 32'(host_rvalid), 32'd0);
    chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    chk("rst_host_rdata", 32'(host_rdata), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      tick();
      #2;
      chk("idle_we", 32'(mem_we), 32'd0);
      chk("idle_adr", 32'(mem_adr), 32'd0);
      chk("idle_stall", 32'(cpu_stall), 32'd0);
      chk("idle_rvalid", 32'(cpu_rvalid | host_rvalid), 32'd0);
    end

    tick(); drive(1, 1, 100, 16'h0007, 0, 0, 0, 0, 0); #2;
    chk("cw_we", 32'(mem_we), 32'd1);
    chk("cw_adr", 32'(mem_adr), 32'd100);
    chk("cw_stall", 32'(cpu_stall), 32'd0);
    tick(); drive(1, 0, 100, 0, 0, 0, 0, 0, 0); #2;
    chk("cr_we", 32'(mem_we), 32'd0);
    chk("cr_adr", 32'(mem_adr), 32'd100);
    tick(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0); #2;
    chk("cr_rvalid", 32'(cpu_rvalid), 32'd1);
    chk("cr_rdata", 32'(cpu_rdata), 32'h0007);

    contention("cont");

    tick(); drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      tick(); drive(1, 0, 50, 0, 1, 1, i, 16'h1000 + i, 1); #2;
      chk("lock_stall", 32'(cpu_stall), 32'd1);
      chk("lock_gnt", 32'(host_gnt), 32'd1);
      chk("lock_adr", 32'(mem_adr), 32'(i));
      chk("lock_wdata", 32'(mem_wdata), 32'(16'h1000 + i));
    end
    tick(); drive(1, 0, 50, 0, 0, 0, 0, 0, 0); #2;
    chk("unlock_tail_stall", 32'(cpu_stall), 32'd1);
    tick(); drive(1, 0, 50, 0, 0, 0, 0, 0, 0); #2;
    chk("unlock_resume_stall", 32'(cpu_stall), 32'd0);
    chk("unlock_resume_adr", 32'(mem_adr), 32'd50);
    tick(); drive(0, 0, 0, 0, 1, 0, 3, 0, 0); #2;
    chk("hr_gnt", 32'(host_gnt), 32'd1);
    tick(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0); #2;
    chk("hr_rvalid", 32'(host_rvalid), 32'd1);
    chk("hr_rdata", 32'(host_rdata), 32'h1003);

    tick(); drive(1, 1, 96, 16'h00AB, 0, 0, 0, 0, 0);
    tick(); drive(1, 0, 96, 0, 0, 0, 0, 0, 0);
    tick(); drive(0, 0, 0, 0, 1, 0, 96, 0, 0); #2;
    chk("il_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
    chk("il_host_rvalid0", 32'(host_rvalid), 32'd0);
    chk("il_cpu_rdata", 32'(cpu_rdata), 32'h00AB);
    tick(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0); #2;
    chk("il_host_rvalid", 32'(host_rvalid), 32'd1);
    chk("il_cpu_rvalid0", 32'(cpu_rvalid), 32'd0);
    chk("il_host_rdata", 32'(host_rdata), 32'h00AB);
    chk("il_cpu_hold", 32'(cpu_rdata), 32'h00AB);

    // Build up host waits, grant a CPU read, and reset on the edge that would return it.
    tick(); drive(1, 0, 10, 0, 1, 0, 20, 0, 0);
    tick(); drive(1, 0, 11, 0, 1, 0, 20, 0, 0);
    tick(); drive(1, 0, 96, 0, 1, 0, 20, 0, 0); #2;
    chk("mr_grant_stall", 32'(cpu_stall), 32'd0);
    reset = 1'b1;
    tick(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0); #2;
    chk("mr_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    chk("mr_host_rvalid", 32'(host_rvalid), 32'd0);
    chk("mr_cpu_rdata", 32'(cpu_rdata), 32'd0);
    chk("mr_host_rdata", 32'(host_rdata), 32'd0);
    reset = 1'b0;
    contention("post_rst");

    hold = 0; hr = 0; hw = 0; ha = 0; hd = 0; lk = 0;
    for (int n = 0; n < 3000; n++) begin
      tick();
      reset = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 19) == 0) lk = !lk;
      cr = ($urandom_range(0, 2) != 0);
      cw = 1'($urandom_range(0, 1));
      ca = int'($urandom_range(0, 63));
      cd = int'($urandom_range(0, 65535));
      if (!hold) begin
        hr = ($urandom_range(0, 2) == 0);
        hw = 1'($urandom_range(0, 1));
        ha = int'($urandom_range(0, 63));
        hd = int'($urandom_range(0, 65535));
      end
      drive(cr, cw, ca, cd, hr, hw, ha, hd, lk);
      #2;
      hold = hr && !host_gnt && !reset;
    end
    reset = 1'b0;
    tick(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
